// File: rtl/alu_core.sv
// 32-bit sequential ALU with ready/valid handshake: INIT -> IDLE -> EXEC -> DONE.
// Define ALU_MUL_EN to enable opcode 8 (iterative 32-cycle shift-add multiply).
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_cmd,
    output logic [WIDTH-1:0] o_result,
    output logic             o_valid,
    output logic             o_ready
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SHL = 4'd3;
    localparam logic [3:0] OP_SHR = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] alu_res;
    logic             shift_big;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mul_step;

    // One shift-add step: a_q holds a<<k, b_q holds b>>k on iteration k.
    assign mul_step = acc_q + (b_q[0] ? a_q : '0);
`endif

    assign shift_big = (b_q >= WIDTH_V);

    always_comb begin
        alu_res = '0;
        case (cmd_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_SHL:  alu_res = shift_big ? '0 : (a_q << b_q[SHW-1:0]);
            OP_SHR:  alu_res = shift_big ? '0 : (a_q >> b_q[SHW-1:0]);
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cmd_d    = cmd_q;
        result_d = result_q;
`ifdef ALU_MUL_EN
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (i_cmd != OP_NOP) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    cmd_d   = i_cmd;
                    state_d = ST_EXEC;
`ifdef ALU_MUL_EN
                    acc_d   = '0;
                    cnt_d   = '0;
`endif
                end
            end
            ST_EXEC: begin
`ifdef ALU_MUL_EN
                if (cmd_q == OP_MUL) begin
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    acc_d = mul_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result_d = mul_step;
                        state_d  = ST_DONE;
                    end
                end else begin
                    result_d = alu_res;
                    state_d  = ST_DONE;
                end
`else
                result_d = alu_res;
                state_d  = ST_DONE;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_INIT;
            a_q      <= '0;
            b_q      <= '0;
            cmd_q    <= OP_NOP;
            result_q <= '0;
`ifdef ALU_MUL_EN
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cmd_q    <= cmd_d;
            result_q <= result_d;
`ifdef ALU_MUL_EN
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Handshake outputs decode straight from the state register, so they never overlap.
    assign o_result = result_q;
    assign o_valid  = (state_q == ST_DONE);
    assign o_ready  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core; expected results are hand-computed constants.
// Honours ALU_MUL_EN to pick the multiply expectations and latency.
module tb_alu_core;

    logic        clk;
    logic        reset_n;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [3:0]  i_cmd;
    logic [31:0] o_result;
    logic        o_valid;
    logic        o_ready;

    int check_cnt = 0;
    int pass_cnt  = 0;

    alu_core #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset_n),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_cmd    (i_cmd),
        .o_result (o_result),
        .o_valid  (o_valid),
        .o_ready  (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one command at an IDLE window, scramble inputs while busy, check result/latency/strobe.
    task automatic run_op(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int waited;
        int n;
        logic busy_ok;
        waited = 0;
        while (!o_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
        i_cmd = cmd;
        i_a   = a;
        i_b   = b;
        @(negedge clk);
        i_cmd = 4'd1;
        i_a   = $urandom;
        i_b   = $urandom;
        n = 1;
        busy_ok = 1'b1;
        while (!o_valid && n < 100) begin
            if (o_ready) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        i_cmd = 4'd0;
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_res"}, o_result, exp);
        check({tag, "_busy"}, {31'd0, busy_ok & ~o_ready}, 32'd1);
        $display("op %-6s cmd=%0d a=0x%08h b=0x%08h -> 0x%08h latency %0d", tag, cmd, a, b, o_result, n);
        @(negedge clk);
        check({tag, "_strobe"}, {30'd0, o_valid, o_ready}, 32'd1);
        check({tag, "_hold"}, o_result, exp);
    endtask

    initial begin
        logic [31:0] mul_a;
        logic [31:0] mul_exp;
        int          mul_lat;
`ifdef ALU_MUL_EN
        mul_exp = 32'h0001_0000;
        mul_lat = 33;
`else
        mul_exp = 32'h0000_0000;
        mul_lat = 2;
`endif
        reset_n = 1'b0;
        i_a = '0;
        i_b = '0;
        i_cmd = 4'd0;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        reset_n = 1'b1;
        #1;
        check("init_ready", {31'd0, o_ready}, 32'd0);
        @(negedge clk);
        check("idle_ready", {31'd0, o_ready}, 32'd1);
        check("idle_valid", {31'd0, o_valid}, 32'd0);

        run_op("shl4",  4'd3, 32'h0000_0001, 32'd4,  32'h0000_0010, 2);
        run_op("shl40", 4'd3, 32'h0000_0001, 32'd40, 32'h0000_0000, 2);
        run_op("add",   4'd1, 32'hFFFF_FFFF, 32'd1,  32'h0000_0000, 2);
        run_op("sub",   4'd2, 32'd3,         32'd5,  32'hFFFF_FFFE, 2);
        run_op("shr31", 4'd4, 32'h8000_0000, 32'd31, 32'h0000_0001, 2);
        run_op("shr32", 4'd4, 32'h8000_0000, 32'd32, 32'h0000_0000, 2);
        run_op("and",   4'd5, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 2);
        run_op("or",    4'd6, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 2);

        i_cmd = 4'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("nop_idle", {30'd0, o_ready, o_valid}, 32'd2);
        end
        check("nop_hold", o_result, 32'hF000_000F);

        run_op("xor",   4'd7, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 2);
        run_op("unsup", 4'hF, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 2);
        run_op("mul",   4'd8, 32'h0001_0000, 32'h0001_0001, mul_exp, mul_lat);
        run_op("add2",  4'd1, 32'd100,       32'd23,       32'd123, 2);
`ifdef ALU_MUL_EN
        mul_a = 32'd7;
        run_op("mul76", 4'd8, mul_a, 32'd6, 32'd42, 33);
`else
        mul_a = 32'd7;
        run_op("mul76", 4'd8, mul_a, 32'd6, 32'd0, 2);
`endif

        // Reset while an ADD sits in EXEC: the operation must vanish.
        i_cmd = 4'd1;
        i_a   = 32'd5;
        i_b   = 32'd6;
        @(negedge clk);
        i_cmd = 4'd0;
        check("mid_busy", {31'd0, o_ready}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_result", o_result, 32'd0);
        check("mid_rst_flags", {30'd0, o_ready, o_valid}, 32'd0);
        @(negedge clk);
        check("mid_rst_novalid", {31'd0, o_valid}, 32'd0);
        reset_n = 1'b1;
        #1;
        check("mid_init_ready", {31'd0, o_ready}, 32'd0);
        @(negedge clk);
        check("mid_idle_flags", {30'd0, o_ready, o_valid}, 32'd2);
        check("mid_idle_result", o_result, 32'd0);

        run_op("restart", 4'd1, 32'd5, 32'd6, 32'd11, 2);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
